// File: rtl/lut_search_pkg.sv
// Shared definitions for the reverse key/data table lookup: FSM state
// encodings, sizing helpers and the entry bit-offset helper.
package lut_search_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SEARCH = 2'd1;
    localparam state_t ST_DONE   = 2'd2;

    // Width of an entry index; a single-entry table still gets one bit.
    function automatic int idx_width(input int nr_key);
        return (nr_key > 1) ? $clog2(nr_key) : 1;
    endfunction

    // Number of LANES-wide groups needed to cover the whole table.
    function automatic int group_count(input int nr_key, input int lanes);
        return (nr_key + lanes - 1) / lanes;
    endfunction

    // LSB of entry i in the packed table; entry 0 sits in the MSBs.
    // The entry is {key, data}, so data starts here and key sits above it.
    function automatic int entry_lsb(input int nr_key, input int ent_w, input int i);
        return (nr_key - 1 - i) * ent_w;
    endfunction

endpackage

// File: rtl/lut_match_group.sv
// Combinational compare of one group of LANES table entries against a data
// value. Lanes past the end of the table never match. When several lanes
// match, the lowest entry index wins.
module lut_match_group
    import lut_search_pkg::*;
#(
    parameter int NR_KEY   = 2,
    parameter int KEY_LEN  = 1,
    parameter int DATA_LEN = 1,
    parameter int LANES    = 1,
    parameter int IDX_W    = 1,
    localparam int ENT_W   = KEY_LEN + DATA_LEN,
    localparam int LUT_W   = NR_KEY * ENT_W
) (
    input  logic [LUT_W-1:0]    lut,
    input  logic [IDX_W-1:0]    base,
    input  logic [DATA_LEN-1:0] data,
    output logic                any_hit,
    output logic [IDX_W-1:0]    hit_idx,
    output logic [KEY_LEN-1:0]  hit_key
);

    // Scan lanes from highest to lowest so the lowest matching index is written last.
    always_comb begin
        any_hit = 1'b0;
        hit_idx = '0;
        hit_key = '0;
        for (int l = LANES - 1; l >= 0; l--) begin : g_lane
            int e;
            int lsb;
            e   = int'(base) + l;
            lsb = 0;
            if (e < NR_KEY) begin
                lsb = entry_lsb(NR_KEY, ENT_W, e);
                if (lut[lsb +: DATA_LEN] == data) begin
                    any_hit = 1'b1;
                    hit_idx = IDX_W'(e);
                    hit_key = lut[lsb + DATA_LEN +: KEY_LEN];
                end
            end
        end
    end

endmodule

// File: rtl/lut_key_search.sv
// Reverse lookup over a packed {key, data} table: returns the key and index
// of the first entry whose data equals the requested value, scanning LANES
// entries per cycle.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. req_ready is high only in IDLE (and out of reset); rsp_valid is high
// only in DONE, and rsp_* stay stable until the consumer raises rsp_ready.
// flush returns to IDLE at the next edge and overrides both handshakes.
module lut_key_search
    import lut_search_pkg::*;
#(
    parameter int                  NR_KEY      = 2,
    parameter int                  KEY_LEN     = 1,
    parameter int                  DATA_LEN    = 1,
    parameter int                  LANES       = 1,
    parameter logic [KEY_LEN-1:0]  DEFAULT_KEY = '0,
    localparam int                 IDX_W       = idx_width(NR_KEY),
    localparam int                 LUT_W       = NR_KEY * (KEY_LEN + DATA_LEN)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [DATA_LEN-1:0] req_data,
    input  logic [LUT_W-1:0]    req_lut,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_hit,
    output logic [KEY_LEN-1:0]  rsp_key,
    output logic [IDX_W-1:0]    rsp_idx
);

    localparam int G  = group_count(NR_KEY, LANES);
    localparam int GW = (G > 1) ? $clog2(G) : 1;

    state_t              state;
    logic [GW-1:0]       grp;
    logic [DATA_LEN-1:0] lat_data;
    logic [LUT_W-1:0]    lat_lut;
    logic [IDX_W-1:0]    base_idx;
    logic                grp_hit;
    logic [IDX_W-1:0]    grp_idx;
    logic [KEY_LEN-1:0]  grp_key;
    logic                last_grp;

    assign base_idx = IDX_W'(int'(grp) * LANES);
    assign last_grp = (int'(grp) == G - 1);

    // Handshake flags come straight from the state; rst_n gating keeps
    // req_ready low while reset is asserted.
    assign req_ready = rst_n && (state == ST_IDLE);
    assign rsp_valid = (state == ST_DONE);

    lut_match_group #(
        .NR_KEY   (NR_KEY),
        .KEY_LEN  (KEY_LEN),
        .DATA_LEN (DATA_LEN),
        .LANES    (LANES),
        .IDX_W    (IDX_W)
    ) u_group (
        .lut     (lat_lut),
        .base    (base_idx),
        .data    (lat_data),
        .any_hit (grp_hit),
        .hit_idx (grp_idx),
        .hit_key (grp_key)
    );

    // Search FSM: latch the request, step one group per cycle, hold the result until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            grp      <= '0;
            lat_data <= '0;
            lat_lut  <= '0;
            rsp_hit  <= 1'b0;
            rsp_key  <= '0;
            rsp_idx  <= '0;
        end else if (flush) begin
            state <= ST_IDLE;
            grp   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        lat_data <= req_data;
                        lat_lut  <= req_lut;
                        grp      <= '0;
                        state    <= ST_SEARCH;
                    end
                end
                ST_SEARCH: begin
                    if (grp_hit) begin
                        rsp_hit <= 1'b1;
                        rsp_key <= grp_key;
                        rsp_idx <= grp_idx;
                        state   <= ST_DONE;
                    end else if (last_grp) begin
                        rsp_hit <= 1'b0;
                        rsp_key <= DEFAULT_KEY;
                        rsp_idx <= '0;
                        state   <= ST_DONE;
                    end else begin
                        grp <= grp + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lut_key_search.sv
// Directed bench for lut_key_search: two instances (4 entries x 1 lane and
// 5 entries x 2 lanes) checked against hand-computed key/index/latency values.
module tb_lut_key_search;

    // 4 entries, key = index, data 11/22/33/44
    localparam logic [39:0] LUT_A  = {2'd0, 8'h11, 2'd1, 8'h22, 2'd2, 8'h33, 2'd3, 8'h44};
    // 5 entries, keys 3,2,1,0,3; entries 3 and 4 share data 77
    localparam logic [49:0] LUT_B1 = {2'd3, 8'h10, 2'd2, 8'h20, 2'd1, 8'h30, 2'd0, 8'h77, 2'd3, 8'h77};
    // 5 entries, entries 0 and 1 share data 10 inside group 0; entry 4 unique 55
    localparam logic [49:0] LUT_B2 = {2'd3, 8'h10, 2'd2, 8'h10, 2'd1, 8'h30, 2'd0, 8'h40, 2'd3, 8'h55};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;

    logic        a_req_valid = 1'b0, a_req_ready, a_rsp_valid, a_rsp_ready = 1'b0, a_rsp_hit;
    logic [7:0]  a_req_data = 8'h00;
    logic [39:0] a_req_lut = LUT_A;
    logic [1:0]  a_rsp_key, a_rsp_idx;

    logic        b_req_valid = 1'b0, b_req_ready, b_rsp_valid, b_rsp_ready = 1'b0, b_rsp_hit;
    logic [7:0]  b_req_data = 8'h00;
    logic [49:0] b_req_lut = LUT_B1;
    logic [1:0]  b_rsp_key;
    logic [2:0]  b_rsp_idx;

    int          sel = 0;
    logic        cur_req_ready, cur_rsp_valid, cur_hit;
    logic [1:0]  cur_key;
    logic [2:0]  cur_idx;

    int          checks = 0;
    int          errors = 0;

    lut_key_search #(
        .NR_KEY(4), .KEY_LEN(2), .DATA_LEN(8), .LANES(1), .DEFAULT_KEY(2'd3)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_data(a_req_data), .req_lut(a_req_lut),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_hit(a_rsp_hit),
        .rsp_key(a_rsp_key), .rsp_idx(a_rsp_idx)
    );

    lut_key_search #(
        .NR_KEY(5), .KEY_LEN(2), .DATA_LEN(8), .LANES(2), .DEFAULT_KEY(2'd1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_data(b_req_data), .req_lut(b_req_lut),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_hit(b_rsp_hit),
        .rsp_key(b_rsp_key), .rsp_idx(b_rsp_idx)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // view of the currently selected instance
    always_comb begin
        cur_req_ready = (sel != 0) ? b_req_ready : a_req_ready;
        cur_rsp_valid = (sel != 0) ? b_rsp_valid : a_rsp_valid;
        cur_hit       = (sel != 0) ? b_rsp_hit   : a_rsp_hit;
        cur_key       = (sel != 0) ? b_rsp_key   : a_rsp_key;
        cur_idx       = (sel != 0) ? b_rsp_idx   : {1'b0, a_rsp_idx};
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic set_req(input int s, input logic v, input logic [7:0] d);
        if (s == 0) begin
            a_req_valid = v;
            a_req_data  = d;
        end else begin
            b_req_valid = v;
            b_req_data  = d;
        end
    endtask

    task automatic set_rsp_ready(input int s, input logic r);
        if (s == 0) a_rsp_ready = r;
        else        b_rsp_ready = r;
    endtask

    // Issue one request, then count cycles until rsp_valid (1 = first cycle after handshake).
    task automatic search(input int s, input logic [7:0] d, output int lat);
        sel = s;
        @(negedge clk);
        check("req_ready_idle", cur_req_ready, 1);
        set_req(s, 1'b1, d);
        @(posedge clk);
        @(negedge clk);
        set_req(s, 1'b0, ~d);
        lat = 1;
        while (!cur_rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic finish_rsp(input int s);
        set_rsp_ready(s, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_rsp_ready(s, 1'b0);
        check("rsp_valid_after_take", cur_rsp_valid, 0);
        check("req_ready_after_take", cur_req_ready, 1);
    endtask

    task automatic run(input string tag, input int s, input logic [7:0] d, input int exp_lat,
                       input logic exp_hit, input logic [1:0] exp_key, input logic [2:0] exp_idx);
        int lat;
        search(s, d, lat);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_hit"}, cur_hit, exp_hit);
        check({tag, "_key"}, cur_key, exp_key);
        check({tag, "_idx"}, cur_idx, exp_idx);
        finish_rsp(s);
    endtask

    initial begin
        int lat;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_a_rsp_valid", a_rsp_valid, 0);
        check("rst_a_hit", a_rsp_hit, 0);
        check("rst_a_key", a_rsp_key, 0);
        check("rst_a_idx", a_rsp_idx, 0);
        check("rst_b_rsp_valid", b_rsp_valid, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_a_req_ready", a_req_ready, 1);
        check("rst_b_req_ready", b_req_ready, 1);

        // single lane, four entries
        run("a_hit2",  0, 8'h33, 4, 1'b1, 2'd2, 3'd2);
        run("a_miss",  0, 8'h55, 5, 1'b0, 2'd3, 3'd0);
        run("a_hit0",  0, 8'h11, 2, 1'b1, 2'd0, 3'd0);
        run("a_hit3",  0, 8'h44, 5, 1'b1, 2'd3, 3'd3);

        // two lanes, five entries (last group half empty)
        run("b_dup34", 1, 8'h77, 3, 1'b1, 2'd0, 3'd3);
        run("b_lane1", 1, 8'h20, 2, 1'b1, 2'd2, 3'd1);
        run("b_miss0", 1, 8'h00, 4, 1'b0, 2'd1, 3'd0);
        run("b_missa", 1, 8'haa, 4, 1'b0, 2'd1, 3'd0);
        b_req_lut = LUT_B2;
        run("b_dup01", 1, 8'h10, 2, 1'b1, 2'd3, 3'd0);
        run("b_hit4",  1, 8'h55, 4, 1'b1, 2'd3, 3'd4);
        run("b_hit2",  1, 8'h30, 3, 1'b1, 2'd1, 3'd2);

        // table changes after acceptance must not affect the search
        sel = 0;
        @(negedge clk);
        set_req(0, 1'b1, 8'h44);
        @(posedge clk);
        @(negedge clk);
        set_req(0, 1'b0, 8'h11);
        a_req_lut = '0;
        lat = 1;
        while (!a_rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latched_lat", lat, 5);
        check("latched_idx", a_rsp_idx, 2'd3);
        check("latched_key", a_rsp_key, 2'd3);
        a_req_lut = LUT_A;
        finish_rsp(0);

        // back-pressure: response held while inputs wiggle
        search(0, 8'h22, lat);
        check("stall_lat", lat, 3);
        for (int i = 0; i < 10; i++) begin
            a_req_valid = ~a_req_valid;
            a_req_data  = 8'(i * 37);
            a_req_lut   = ~a_req_lut;
            @(negedge clk);
            check("stall_rsp_valid", a_rsp_valid, 1);
            check("stall_hit", a_rsp_hit, 1);
            check("stall_key", a_rsp_key, 2'd1);
            check("stall_idx", a_rsp_idx, 2'd1);
            check("stall_req_ready", a_req_ready, 0);
        end
        a_req_valid = 1'b0;
        a_req_lut   = LUT_A;
        finish_rsp(0);
        run("after_stall", 0, 8'h11, 2, 1'b1, 2'd0, 3'd0);

        // flush during SEARCH
        @(negedge clk);
        set_req(0, 1'b1, 8'h44);
        @(posedge clk);
        @(negedge clk);
        set_req(0, 1'b0, 8'h00);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_search_ready", a_req_ready, 1);
        for (int i = 0; i < 6; i++) begin
            check("flush_search_no_rsp", a_rsp_valid, 0);
            @(negedge clk);
        end

        // flush during DONE with the consumer not ready
        search(0, 8'h11, lat);
        check("flush_done_valid", a_rsp_valid, 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_done_no_rsp", a_rsp_valid, 0);
        check("flush_done_ready", a_req_ready, 1);

        // flush beats a request handshake in IDLE
        set_req(0, 1'b1, 8'h11);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        set_req(0, 1'b0, 8'h00);
        check("flush_idle_ready", a_req_ready, 1);
        repeat (3) @(negedge clk);
        check("flush_idle_no_rsp", a_rsp_valid, 0);

        // async reset mid-search clears held result registers
        run("pre_reset", 0, 8'h33, 4, 1'b1, 2'd2, 3'd2);
        @(negedge clk);
        set_req(0, 1'b1, 8'h44);
        @(posedge clk);
        @(negedge clk);
        set_req(0, 1'b0, 8'h00);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_hit", a_rsp_hit, 0);
        check("async_rst_key", a_rsp_key, 0);
        check("async_rst_idx", a_rsp_idx, 0);
        check("async_rst_valid", a_rsp_valid, 0);
        check("async_rst_ready", a_req_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", a_req_ready, 1);
        check("post_rst_valid", a_rsp_valid, 0);
        run("post_rst_hit", 0, 8'h22, 3, 1'b1, 2'd1, 3'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
